lc4_wb_arbiter_ss: RTL and testbench
====================================

Name: lc4_wb_arbiter_ss

Overview:
- Write-port arbiter in front of the dual-write-port superscalar register file.
- Pipes A and B own the two regfile write ports and are never stalled.
- A third source, the long-latency return port L (multi-cycle unit / memory return), is buffered in a DEPTH-entry FIFO. Entries drain into whichever write port the pipes leave idle.
- Also tracks which registers have a pending L write, so decode can stall on them, and squashes buffered L writes made stale by younger pipe writes.

Parameters:
n, 16, data width
DEPTH, 4, L FIFO entries (power of 2, >=2)

Ports:
clk  in  1  clock, all state updates on posedge
rst  in  1  synchronous, active-low reset
gwe  in  1  global write enable; state updates only when 1 (reset excepted)
i_rd_A  in  3  pipe A destination
i_wdata_A  in  n  pipe A write data
i_we_A  in  1  pipe A write enable
i_rd_B  in  3  pipe B destination
i_wdata_B  in  n  pipe B write data
i_we_B  in  1  pipe B write enable
i_l_valid  in  1  L return valid
i_l_rd  in  3  L destination
i_l_data  in  n  L data
o_l_ready  out  1  FIFO can accept (count < DEPTH)
o_rf_rd_A  out  3  to regfile write port A
o_rf_wdata_A  out  n
o_rf_we_A  out  1
o_rf_rd_B  out  3  to regfile write port B
o_rf_wdata_B  out  n
o_rf_we_B  out  1
o_pending  out  8  bit r = some valid FIFO entry targets register r
o_count  out  log2(DEPTH)+1  FIFO occupancy

Behaviour:
- Reset: sampled when rst==0 at posedge, independent of gwe.
  - Head, tail and count go to 0; all entry valid bits go to 0.
  - After reset: o_pending=0, o_count=0, o_l_ready=1, and o_rf_we_A/B are driven only by the pipes.
  - A reset in mid-drain discards all buffered entries.
- Push:
  - Occurs when i_l_valid & o_l_ready & gwe; the entry is written at tail and tail advances, wrapping modulo DEPTH.
  - o_l_ready depends on registered count only, so there is no push-when-full even if a pop happens in the same cycle.
- Latency: an entry pushed at edge t is eligible to drain no earlier than cycle t+1. There is no bypass from i_l_* to o_rf_*.
- Port selection (combinational):
  - Pipe ports pass through unchanged: o_rf_*_A = i_*_A, o_rf_*_B = i_*_B.
  - If FIFO is non-empty and i_we_A==0, the head drains on port A.
  - Else if i_we_B==0, the head drains on port B.
  - Else nothing drains. At most one pop per cycle.
- Ordering rule: pipe writes in cycle t are younger than every L entry present or arriving in cycle t.
  - Squash: at the edge, every valid entry whose rd equals an active pipe rd (i_we_A & i_rd_A, or i_we_B & i_rd_B) has its valid bit cleared. This includes an entry being pushed that same cycle.
  - Drain suppression: if the selected head is invalid, or its rd matches an active pipe rd this cycle, the drain-port we is forced to 0. The head still pops (consumes the slot).
  - Consequence: a stale L write never overwrites a younger value, regardless of the regfile's B-wins rule.
- Count: count_next = count + push - pop. Simultaneous push and pop (count < DEPTH) leaves count unchanged, and head and tail both advance.
- o_pending: OR over valid entries of a one-hot decode of rd. It is derived from registered state only, with no dependence on this cycle's inputs.
- gwe==0: no push, pop or squash takes effect. o_rf_* are still driven combinationally, and the bench holds pipe we=0 in such cycles.

Test Plan:
- Reset then idle: rst=0 for one edge, then rst=1 → o_count=0, o_pending=8'h00, o_l_ready=1, o_rf_we_A=o_rf_we_B=0.
- Single L, pipes idle: push rd=3, data=16'hBEEF at edge 1 → in cycle 2, o_rf_we_A=1, rd_A=3, wdata_A=16'hBEEF; o_pending=8'h08 in cycle 2 and 8'h00 after edge 2.
- Both pipes busy for 5 cycles while 4 L pushes (rd=1,2,4,5) arrive → o_count reaches 4 and o_l_ready=0. A 5th push is not accepted. When the pipes go idle, entries drain one per cycle in order 1,2,4,5.
- Pipe A busy (rd=0) with FIFO head rd=6 → head drains on port B: o_rf_we_B=1, o_rf_rd_B=6; port A shows the pipe write.
- Squash: FIFO holds rd=2 (data 16'h1111) while pipe B writes rd=2 with 16'h2222 → after the edge, o_pending bit2=0. When the stale entry reaches the head it pops with both o_rf_we=0, and the regfile keeps 16'h2222.
- Push and pop together at count=2 → count stays 2. Then assert rst=0 with count=3 → all entries are lost, o_count=0, and no further L writes appear.

Source files
------------

// File: rtl/lc4_wb_arbiter_ss.sv
// lc4_wb_arbiter_ss -- write-back arbiter for the dual-write-port register file.
//
// Pipes A and B own the two regfile write ports and pass straight through.
// Long-latency returns (port L) are queued in a DEPTH-entry FIFO and drain
// through whichever write port the pipes leave idle (A preferred, then B).
// Buffered L writes made stale by a younger pipe write to the same register
// are squashed, and o_pending reports registers with an outstanding L write.
//
// Ports:
//   clk, rst (sync, active-low), gwe (global write enable)
//   i_rd_A / i_wdata_A / i_we_A   pipe A write
//   i_rd_B / i_wdata_B / i_we_B   pipe B write
//   i_l_valid / i_l_rd / i_l_data L return; o_l_ready = FIFO not full
//   o_rf_*_A, o_rf_*_B            regfile write ports
//   o_pending                     bit r set when a valid entry targets r
//   o_count                       FIFO occupancy
module lc4_wb_arbiter_ss #(
  parameter int unsigned n     = 16,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     gwe,
  input  logic [2:0]               i_rd_A,
  input  logic [n-1:0]             i_wdata_A,
  input  logic                     i_we_A,
  input  logic [2:0]               i_rd_B,
  input  logic [n-1:0]             i_wdata_B,
  input  logic                     i_we_B,
  input  logic                     i_l_valid,
  input  logic [2:0]               i_l_rd,
  input  logic [n-1:0]             i_l_data,
  output logic                     o_l_ready,
  output logic [2:0]               o_rf_rd_A,
  output logic [n-1:0]             o_rf_wdata_A,
  output logic                     o_rf_we_A,
  output logic [2:0]               o_rf_rd_B,
  output logic [n-1:0]             o_rf_wdata_B,
  output logic                     o_rf_we_B,
  output logic [7:0]               o_pending,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int unsigned AW = $clog2(DEPTH);
  // DEPTH is a power of two, so "full" is the MSB alone.
  localparam logic [AW:0] FULL = {1'b1, {AW{1'b0}}};

  logic [2:0]    ent_rd   [DEPTH];
  logic [n-1:0]  ent_data [DEPTH];
  logic          ent_vld  [DEPTH];
  logic [AW-1:0] head, tail;
  logic [AW:0]   count;

  logic          kill     [DEPTH];
  logic          l_kill;
  logic          head_stale;
  logic          drain_A, drain_B, drain_we;
  logic          push, pop;

  always_comb begin
    for (int unsigned i = 0; i < DEPTH; i++) begin
      kill[i] = (i_we_A && (ent_rd[i] == i_rd_A)) ||
                (i_we_B && (ent_rd[i] == i_rd_B));
    end
    l_kill     = (i_we_A && (i_l_rd == i_rd_A)) || (i_we_B && (i_l_rd == i_rd_B));
    head_stale = (i_we_A && (ent_rd[head] == i_rd_A)) ||
                 (i_we_B && (ent_rd[head] == i_rd_B));

    o_l_ready = (count != FULL);
    drain_A   = (count != '0) && !i_we_A;
    drain_B   = (count != '0) && i_we_A && !i_we_B;
    // A squashed or stale head still pops, it just writes nothing.
    drain_we  = ent_vld[head] && !head_stale;
    push      = i_l_valid && o_l_ready;
    pop       = drain_A || drain_B;

    o_rf_rd_A    = drain_A ? ent_rd[head]   : i_rd_A;
    o_rf_wdata_A = drain_A ? ent_data[head] : i_wdata_A;
    o_rf_we_A    = drain_A ? drain_we       : i_we_A;
    o_rf_rd_B    = drain_B ? ent_rd[head]   : i_rd_B;
    o_rf_wdata_B = drain_B ? ent_data[head] : i_wdata_B;
    o_rf_we_B    = drain_B ? drain_we       : i_we_B;

    o_pending = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (ent_vld[i]) o_pending[ent_rd[i]] = 1'b1;
    end
    o_count = count;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) ent_vld[i] <= 1'b0;
    end else if (gwe) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        if (kill[i]) ent_vld[i] <= 1'b0;
      end
      // Popped slots are invalidated so o_pending only sees live entries.
      // head != tail whenever both push and pop occur, so no slot conflict.
      if (pop) begin
        ent_vld[head] <= 1'b0;
        head          <= head + 1'b1;
      end
      if (push) begin
        ent_rd[tail]   <= i_l_rd;
        ent_data[tail] <= i_l_data;
        ent_vld[tail]  <= !l_kill;
        tail           <= tail + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_lc4_wb_arbiter_ss.sv
// Self-checking bench for lc4_wb_arbiter_ss: directed scenarios plus a
// randomized run against a queue-based reference model.
module tb_lc4_wb_arbiter_ss;

  localparam int unsigned N     = 16;
  localparam int unsigned DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst, gwe;
  logic [2:0]  i_rd_A, i_rd_B, i_l_rd;
  logic [15:0] i_wdata_A, i_wdata_B, i_l_data;
  logic        i_we_A, i_we_B, i_l_valid;
  logic        o_l_ready;
  logic [2:0]  o_rf_rd_A, o_rf_rd_B;
  logic [15:0] o_rf_wdata_A, o_rf_wdata_B;
  logic        o_rf_we_A, o_rf_we_B;
  logic [7:0]  o_pending;
  logic [2:0]  o_count;

  always #5 clk = ~clk;

  lc4_wb_arbiter_ss #(.n(N), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .gwe(gwe),
    .i_rd_A(i_rd_A), .i_wdata_A(i_wdata_A), .i_we_A(i_we_A),
    .i_rd_B(i_rd_B), .i_wdata_B(i_wdata_B), .i_we_B(i_we_B),
    .i_l_valid(i_l_valid), .i_l_rd(i_l_rd), .i_l_data(i_l_data),
    .o_l_ready(o_l_ready),
    .o_rf_rd_A(o_rf_rd_A), .o_rf_wdata_A(o_rf_wdata_A), .o_rf_we_A(o_rf_we_A),
    .o_rf_rd_B(o_rf_rd_B), .o_rf_wdata_B(o_rf_wdata_B), .o_rf_we_B(o_rf_we_B),
    .o_pending(o_pending), .o_count(o_count)
  );

  // Register file fed by the arbiter outputs; port B wins on collision.
  logic [15:0] rf [8];
  always @(posedge clk) begin
    if (gwe) begin
      if (o_rf_we_A) rf[o_rf_rd_A] <= o_rf_wdata_A;
      if (o_rf_we_B) rf[o_rf_rd_B] <= o_rf_wdata_B;
    end
  end

  // Reference model: ordered list of buffered L writes.
  typedef struct {
    logic [2:0]  rd;
    logic [15:0] data;
    bit          vld;
  } ent_t;
  ent_t q[$];

  int n_cmp  = 0;
  int n_fail = 0;

  logic        e_ready, e_we_A, e_we_B;
  logic [2:0]  e_rd_A, e_rd_B, e_count;
  logic [15:0] e_wd_A, e_wd_B;
  logic [7:0]  e_pending;

  function automatic bit pipe_hit(logic [2:0] r);
    return (i_we_A && i_rd_A == r) || (i_we_B && i_rd_B == r);
  endfunction

  task automatic model_comb();
    e_count   = 3'(q.size());
    e_ready   = (q.size() < DEPTH);
    e_pending = '0;
    foreach (q[k]) if (q[k].vld) e_pending[q[k].rd] = 1'b1;
    e_rd_A = i_rd_A; e_wd_A = i_wdata_A; e_we_A = i_we_A;
    e_rd_B = i_rd_B; e_wd_B = i_wdata_B; e_we_B = i_we_B;
    if (q.size() > 0) begin
      if (!i_we_A) begin
        e_rd_A = q[0].rd; e_wd_A = q[0].data; e_we_A = q[0].vld && !pipe_hit(q[0].rd);
      end else if (!i_we_B) begin
        e_rd_B = q[0].rd; e_wd_B = q[0].data; e_we_B = q[0].vld && !pipe_hit(q[0].rd);
      end
    end
  endtask

  task automatic model_edge();
    bit   push_ok, pop_ok, lv;
    ent_t e;
    if (!rst) begin
      q.delete();
      return;
    end
    if (!gwe) return;
    push_ok = i_l_valid && (q.size() < DEPTH);
    pop_ok  = (q.size() > 0) && (!i_we_A || !i_we_B);
    lv      = !pipe_hit(i_l_rd);
    foreach (q[k]) if (pipe_hit(q[k].rd)) q[k].vld = 1'b0;
    if (pop_ok) void'(q.pop_front());
    if (push_ok) begin
      e.rd = i_l_rd; e.data = i_l_data; e.vld = lv;
      q.push_back(e);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic idle();
    rst = 1'b1; gwe = 1'b1;
    i_we_A = 1'b0; i_rd_A = '0; i_wdata_A = '0;
    i_we_B = 1'b0; i_rd_B = '0; i_wdata_B = '0;
    i_l_valid = 1'b0; i_l_rd = '0; i_l_data = '0;
  endtask

  task automatic test_reset();
    idle();
    rst = 1'b0; gwe = 1'b0;
    tick();
    rst = 1'b1; gwe = 1'b1;
    #2;
    n_cmp++; if (o_count !== 3'd0) begin n_fail++; $display("FAIL reset_count got %0d want 0", o_count); end
    n_cmp++; if (o_pending !== 8'h00) begin n_fail++; $display("FAIL reset_pending got %h want 00", o_pending); end
    n_cmp++; if (o_l_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready got %b want 1", o_l_ready); end
    n_cmp++; if ({o_rf_we_A, o_rf_we_B} !== 2'b00) begin n_fail++; $display("FAIL reset_we got %b want 00", {o_rf_we_A, o_rf_we_B}); end
  endtask

  task automatic test_single();
    idle();
    i_l_valid = 1'b1; i_l_rd = 3'd3; i_l_data = 16'hBEEF;
    #2;
    n_cmp++; if (o_rf_we_A !== 1'b0) begin n_fail++; $display("FAIL single_nobypass got %b want 0", o_rf_we_A); end
    tick();
    i_l_valid = 1'b0;
    #2;
    n_cmp++; if ({o_rf_we_A, o_rf_rd_A, o_rf_wdata_A} !== {1'b1, 3'd3, 16'hBEEF})
      begin n_fail++; $display("FAIL single_drain got we=%b rd=%0d d=%h want 1/3/beef", o_rf_we_A, o_rf_rd_A, o_rf_wdata_A); end
    n_cmp++; if (o_pending !== 8'h08) begin n_fail++; $display("FAIL single_pend got %h want 08", o_pending); end
    tick();
    #2;
    n_cmp++; if (o_pending !== 8'h00) begin n_fail++; $display("FAIL single_pend_clr got %h want 00", o_pending); end
    n_cmp++; if (o_count !== 3'd0) begin n_fail++; $display("FAIL single_count got %0d want 0", o_count); end
  endtask

  task automatic test_fill();
    logic [2:0] tbl [5];
    tbl[0] = 3'd1; tbl[1] = 3'd2; tbl[2] = 3'd4; tbl[3] = 3'd5; tbl[4] = 3'd6;
    idle();
    i_we_A = 1'b1; i_rd_A = 3'd0; i_wdata_A = 16'($urandom);
    i_we_B = 1'b1; i_rd_B = 3'd7; i_wdata_B = 16'($urandom);
    for (int k = 0; k < 5; k++) begin
      i_l_valid = 1'b1; i_l_rd = tbl[k]; i_l_data = 16'(16'h100 + k);
      #2;
      if (k == 4) begin
        n_cmp++; if (o_l_ready !== 1'b0) begin n_fail++; $display("FAIL fill_ready got %b want 0", o_l_ready); end
        n_cmp++; if (o_count !== 3'd4) begin n_fail++; $display("FAIL fill_count got %0d want 4", o_count); end
      end
      tick();
    end
    idle();
    #2;
    n_cmp++; if (o_pending !== 8'h36) begin n_fail++; $display("FAIL fill_pend got %h want 36", o_pending); end
    n_cmp++; if (o_count !== 3'd4) begin n_fail++; $display("FAIL fill_no5th got %0d want 4", o_count); end
    for (int k = 0; k < 4; k++) begin
      #1;
      n_cmp++; if ({o_rf_we_A, o_rf_rd_A, o_rf_wdata_A} !== {1'b1, tbl[k], 16'(16'h100 + k)})
        begin n_fail++; $display("FAIL fill_order%0d got we=%b rd=%0d d=%h want 1/%0d/%h", k, o_rf_we_A, o_rf_rd_A, o_rf_wdata_A, tbl[k], 16'(16'h100 + k)); end
      tick();
    end
    #2;
    n_cmp++; if (o_count !== 3'd0) begin n_fail++; $display("FAIL fill_empty got %0d want 0", o_count); end
  endtask

  task automatic test_port_b();
    logic [15:0] d;
    d = 16'($urandom);
    idle();
    i_we_A = 1'b1; i_rd_A = 3'd0; i_wdata_A = 16'h0A0A;
    i_l_valid = 1'b1; i_l_rd = 3'd6; i_l_data = d;
    tick();
    i_l_valid = 1'b0;
    #2;
    n_cmp++; if ({o_rf_we_B, o_rf_rd_B, o_rf_wdata_B} !== {1'b1, 3'd6, d})
      begin n_fail++; $display("FAIL portb_drain got we=%b rd=%0d d=%h want 1/6/%h", o_rf_we_B, o_rf_rd_B, o_rf_wdata_B, d); end
    n_cmp++; if ({o_rf_we_A, o_rf_rd_A, o_rf_wdata_A} !== {1'b1, 3'd0, 16'h0A0A})
      begin n_fail++; $display("FAIL portb_pipeA got we=%b rd=%0d d=%h want 1/0/0a0a", o_rf_we_A, o_rf_rd_A, o_rf_wdata_A); end
    tick();
    idle();
    #2;
    n_cmp++; if (o_count !== 3'd0) begin n_fail++; $display("FAIL portb_count got %0d want 0", o_count); end
  endtask

  task automatic test_squash();
    idle();
    i_we_A = 1'b1; i_rd_A = 3'd0; i_we_B = 1'b1; i_rd_B = 3'd7;
    i_l_valid = 1'b1; i_l_rd = 3'd2; i_l_data = 16'h1111;
    tick();
    i_l_valid = 1'b0;
    i_rd_B = 3'd2; i_wdata_B = 16'h2222;
    #2;
    n_cmp++; if (o_pending !== 8'h04) begin n_fail++; $display("FAIL squash_pend_before got %h want 04", o_pending); end
    tick();
    idle();
    #2;
    n_cmp++; if (o_pending !== 8'h00) begin n_fail++; $display("FAIL squash_pend_after got %h want 00", o_pending); end
    n_cmp++; if (o_count !== 3'd1) begin n_fail++; $display("FAIL squash_count got %0d want 1", o_count); end
    n_cmp++; if ({o_rf_we_A, o_rf_we_B} !== 2'b00) begin n_fail++; $display("FAIL squash_we got %b want 00", {o_rf_we_A, o_rf_we_B}); end
    tick();
    #2;
    n_cmp++; if (o_count !== 3'd0) begin n_fail++; $display("FAIL squash_pop got %0d want 0", o_count); end
    n_cmp++; if (rf[2] !== 16'h2222) begin n_fail++; $display("FAIL squash_rf got %h want 2222", rf[2]); end
  endtask

  task automatic test_push_pop_reset();
    idle();
    i_we_A = 1'b1; i_rd_A = 3'd0; i_we_B = 1'b1; i_rd_B = 3'd7;
    i_l_valid = 1'b1; i_l_rd = 3'd1; i_l_data = 16'hAAAA;
    tick();
    i_l_rd = 3'd3; i_l_data = 16'hBBBB;
    tick();
    #1;
    n_cmp++; if (o_count !== 3'd2) begin n_fail++; $display("FAIL pp_count2 got %0d want 2", o_count); end
    i_we_A = 1'b0; i_we_B = 1'b0;
    i_l_rd = 3'd4; i_l_data = 16'hCCCC;
    tick();
    #1;
    n_cmp++; if (o_count !== 3'd2) begin n_fail++; $display("FAIL pp_same got %0d want 2", o_count); end
    i_we_A = 1'b1; i_we_B = 1'b1;
    i_l_rd = 3'd5; i_l_data = 16'hDDDD;
    tick();
    #1;
    n_cmp++; if (o_count !== 3'd3) begin n_fail++; $display("FAIL pp_count3 got %0d want 3", o_count); end
    idle();
    rst = 1'b0;
    tick();
    rst = 1'b1;
    #2;
    n_cmp++; if ({o_count, o_pending, o_l_ready} !== {3'd0, 8'h00, 1'b1})
      begin n_fail++; $display("FAIL pp_reset got cnt=%0d pend=%h rdy=%b want 0/00/1", o_count, o_pending, o_l_ready); end
    for (int k = 0; k < 3; k++) begin
      n_cmp++; if ({o_rf_we_A, o_rf_we_B} !== 2'b00) begin n_fail++; $display("FAIL pp_after_rst%0d got %b want 00", k, {o_rf_we_A, o_rf_we_B}); end
      tick();
      #1;
    end
  endtask

  task automatic test_random();
    idle();
    for (int c = 0; c < 600; c++) begin
      rst = ($urandom_range(0, 59) != 0);
      gwe = ($urandom_range(0, 7) != 0);
      i_we_A = gwe && ($urandom_range(0, 9) < 6);
      i_we_B = gwe && ($urandom_range(0, 9) < 6);
      i_rd_A = 3'($urandom); i_wdata_A = 16'($urandom);
      i_rd_B = 3'($urandom); i_wdata_B = 16'($urandom);
      i_l_valid = ($urandom_range(0, 9) < 6);
      i_l_rd = 3'($urandom); i_l_data = 16'($urandom);
      #2;
      model_comb();
      n_cmp++; if (o_count !== e_count) begin n_fail++; $display("FAIL rnd_count c=%0d got %0d want %0d", c, o_count, e_count); end
      n_cmp++; if (o_l_ready !== e_ready) begin n_fail++; $display("FAIL rnd_ready c=%0d got %b want %b", c, o_l_ready, e_ready); end
      n_cmp++; if (o_pending !== e_pending) begin n_fail++; $display("FAIL rnd_pend c=%0d got %h want %h", c, o_pending, e_pending); end
      n_cmp++; if (o_rf_we_A !== e_we_A) begin n_fail++; $display("FAIL rnd_weA c=%0d got %b want %b", c, o_rf_we_A, e_we_A); end
      n_cmp++; if (o_rf_we_B !== e_we_B) begin n_fail++; $display("FAIL rnd_weB c=%0d got %b want %b", c, o_rf_we_B, e_we_B); end
      n_cmp++; if (o_rf_rd_A !== e_rd_A) begin n_fail++; $display("FAIL rnd_rdA c=%0d got %0d want %0d", c, o_rf_rd_A, e_rd_A); end
      n_cmp++; if (o_rf_rd_B !== e_rd_B) begin n_fail++; $display("FAIL rnd_rdB c=%0d got %0d want %0d", c, o_rf_rd_B, e_rd_B); end
      n_cmp++; if (o_rf_wdata_A !== e_wd_A) begin n_fail++; $display("FAIL rnd_wdA c=%0d got %h want %h", c, o_rf_wdata_A, e_wd_A); end
      n_cmp++; if (o_rf_wdata_B !== e_wd_B) begin n_fail++; $display("FAIL rnd_wdB c=%0d got %h want %h", c, o_rf_wdata_B, e_wd_B); end
      tick();
    end
  endtask

  initial begin
    idle();
    test_reset();
    test_single();
    test_fill();
    test_port_b();
    test_squash();
    test_push_pop_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
